// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with oversampling, one-entry holding
// register (valid/ack), framing-error pulse and sticky overrun flag.
// Build option: define UART_RX_MAJORITY_EN to decide every sample point by a
// 2-of-3 vote around the nominal point (all timing shifts one cycle later).
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned H = CLKS_PER_BIT / 2;
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  // Start decision one cycle late; DATA/STOP inherit the offset from there.
  localparam logic [7:0] START_PT = 8'(H);
`else
  localparam logic [7:0] START_PT = 8'(H - 1);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t                 state, state_n;
  logic [7:0]             cnt, cnt_n;
  logic [2:0]             bidx, bidx_n;
  logic [7:0]             shift, shift_n;
  logic                   done, ferr;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   smp;

  // Input synchronizer, preset high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic rx_d1, rx_d2;

  // Two-deep history of rx_s: at nominal+1, rx_d2/rx_d1/rx_s span the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  assign smp = (rx_d2 & rx_d1) | (rx_d2 & rx_s) | (rx_d1 & rx_s);
`else
  assign smp = rx_s;
`endif

  // FSM state, bit timing and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bidx  <= bidx_n;
      shift <= shift_n;
    end
  end

  // Next-state logic: start qualification, data sampling, stop check.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bidx_n  = bidx;
    shift_n = shift;
    done    = 1'b0;
    ferr    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == START_PT) begin
          cnt_n   = '0;
          bidx_n  = '0;
          state_n = smp ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n         = '0;
          shift_n[bidx] = smp;
          if (bidx == 3'd7) state_n = STOP;
          else              bidx_n  = bidx + 3'd1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          done    = smp;
          ferr    = !smp;
          state_n = smp ? IDLE : BREAK;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Holding register: accept on empty or simultaneous ack, else flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr;
      if (done) begin
        if (data_valid && !data_ack) begin
          overrun <= 1'b1;
        end else begin
          data_out   <= shift;
          data_valid <= 1'b1;
          overrun    <= 1'b0;
        end
      end else if (data_valid && data_ack) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT=16, SYNC_STAGES=2).
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 156;
  localparam logic [7:0] EXP_GLITCH = 8'h00;
`else
  localparam int LAT = 155;
  localparam logic [7:0] EXP_GLITCH = 8'h08;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, busy, frame_err, overrun;

  int n_vec = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  int fe_b;

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    logic       ack;
    logic [7:0] exp_out;
    logic       exp_dv;
    logic       exp_ov;
    int         exp_fe;
  } vec_t;

  vec_t tbl [6];

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
    logic [7:0] bb;
    bb = b;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = bb[i];
      tick(CPB);
    end
    rx = stop_v;
    tick(CPB * stop_len);
    rx = 1'b1;
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    tick(1);
    data_ack = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out"},  data_out,        8'h00);
    check({tag, "_dv"},   8'(data_valid),  8'h00);
    check({tag, "_busy"}, 8'(busy),        8'h00);
    check({tag, "_fe"},   8'(frame_err),   8'h00);
    check({tag, "_ov"},   8'(overrun),     8'h00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 0};
    tbl[1] = '{8'hFF, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 0};
    tbl[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0};
    tbl[3] = '{8'h81, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 0};
    tbl[5] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 0};

    // Reset values
    tick(3);
    check_reset("rst0");
    rst_n = 1'b1;
    tick(3);

    // First frame: exact latency, busy during frame
    fe_b = fe_cnt;
    fork
      send_frame(8'hA5, 1'b1, 1);
      begin
        tick(80);
        check("a5_busy_mid", 8'(busy), 8'h01);
        tick(LAT - 81);
        check("a5_dv_early", 8'(data_valid), 8'h00);
        tick(1);
        check("a5_dv", 8'(data_valid), 8'h01);
        check("a5_out", data_out, 8'hA5);
      end
    join
    tick(2);
    check("a5_busy_end", 8'(busy), 8'h00);
    check("a5_fe", 8'(fe_cnt - fe_b), 8'h00);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].ack) ack_pulse();
      fe_b = fe_cnt;
      send_frame(tbl[i].data, tbl[i].stop_v, 1);
      tick(4);
      check($sformatf("v%0d_out", i), data_out, tbl[i].exp_out);
      check($sformatf("v%0d_dv", i), 8'(data_valid), 8'(tbl[i].exp_dv));
      check($sformatf("v%0d_ov", i), 8'(overrun), 8'(tbl[i].exp_ov));
      check($sformatf("v%0d_fe", i), 8'(fe_cnt - fe_b), 8'(tbl[i].exp_fe));
      check($sformatf("v%0d_busy", i), 8'(busy), 8'h00);
    end

    // Ack arriving in the same cycle a byte completes
    fork
      send_frame(8'h99, 1'b1, 1);
      begin
        tick(LAT - 1);
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        check("same_out", data_out, 8'h99);
        check("same_dv", 8'(data_valid), 8'h01);
        check("same_ov", 8'(overrun), 8'h00);
      end
    join
    tick(4);
    check("same_dv_hold", 8'(data_valid), 8'h01);

    // Short start glitch aborts at half-bit
    ack_pulse();
    fe_b = fe_cnt;
    rx = 1'b0;
    tick(4);
    check("glitch_busy_on", 8'(busy), 8'h01);
    rx = 1'b1;
    tick(20);
    check("glitch_busy_off", 8'(busy), 8'h00);
    check("glitch_dv", 8'(data_valid), 8'h00);
    check("glitch_ov", 8'(overrun), 8'h00);
    check("glitch_fe", 8'(fe_cnt - fe_b), 8'h00);

    // Break: stop held low two bit times
    fe_b = fe_cnt;
    fork
      send_frame(8'h3C, 1'b0, 2);
      begin
        tick(175);
        check("brk_busy", 8'(busy), 8'h01);
        check("brk_dv", 8'(data_valid), 8'h00);
      end
    join
    tick(4);
    check("brk_fe", 8'(fe_cnt - fe_b), 8'h01);
    check("brk_idle", 8'(busy), 8'h00);
    send_frame(8'h55, 1'b1, 1);
    tick(4);
    check("brk_next_out", data_out, 8'h55);
    check("brk_next_dv", 8'(data_valid), 8'h01);

    // Back-to-back frames without ack
    ack_pulse();
    send_frame(8'h11, 1'b1, 1);
    send_frame(8'h22, 1'b1, 1);
    tick(4);
    check("b2b_out", data_out, 8'h11);
    check("b2b_dv", 8'(data_valid), 8'h01);
    check("b2b_ov", 8'(overrun), 8'h01);
    ack_pulse();
    check("b2b_ack_dv", 8'(data_valid), 8'h00);
    check("b2b_ack_ov", 8'(overrun), 8'h00);

    // Reset in the middle of a byte
    send_frame(8'h42, 1'b1, 1);
    tick(4);
    check("pre_rst_out", data_out, 8'h42);
    rx = 1'b0;
    tick(84);
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    tick(2);
    rx = 1'b1;
    tick(1);
    check_reset("rst_hold");
    rst_n = 1'b1;
    tick(5);
    check("rst_after_busy", 8'(busy), 8'h00);
    send_frame(8'h7E, 1'b1, 1);
    tick(4);
    check("rst_7e_out", data_out, 8'h7E);
    check("rst_7e_dv", 8'(data_valid), 8'h01);
    check("rst_7e_ov", 8'(overrun), 8'h00);

    // One-cycle high glitch at the nominal sample of data bit 3
    ack_pulse();
    fork
      send_frame(8'h00, 1'b1, 1);
      begin
        tick(72);
        rx = 1'b1;
        tick(1);
        rx = 1'b0;
      end
    join
    tick(4);
    check("bitglitch_out", data_out, EXP_GLITCH);
    check("bitglitch_dv", 8'(data_valid), 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the 8N1 frame produced by the team's uart_tx: start bit 0, 8 data bits LSB first, stop bit 1.
- Oversamples the asynchronous rx line at CLKS_PER_BIT clocks per bit and reassembles bytes.
- Presents each byte on a one-entry holding register with a valid/ack handshake to downstream logic.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..255.
- SYNC_STAGES, 2, flops in the rx input synchronizer; legal range 2..3.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  serial line, asynchronous, idles high
- data_out  output  8  last correctly received byte
- data_valid  output  1  data_out holds an unconsumed byte
- data_ack  input  1  consumer takes data_out; only meaningful while data_valid=1
- busy  output  1  frame reception in progress (state != IDLE)
- frame_err  output  1  one-cycle pulse when the stop bit samples 0
- overrun  output  1  sticky; a byte completed while data_valid=1; cleared by data_ack

Behaviour:
- Reset (rst_n=0, asynchronous):
  - data_out=0x00, data_valid=0, busy=0, frame_err=0, overrun=0.
  - State=IDLE, counters cleared.
  - Synchronizer flops are set to 1 so no false start bit is seen.
- Synchronizer: rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s. Pin-to-rx_s latency is SYNC_STAGES cycles.
- Bit counter: cnt, 8 bits, counts 0..CLKS_PER_BIT-1. Bit index: bidx, 3 bits. Let H = CLKS_PER_BIT/2, integer division.
- State machine:
  - IDLE: when rx_s=0, go to START with cnt=0.
  - START: cnt increments. At cnt=H-1, sample rx_s:
    - 0: go to DATA, cnt=0, bidx=0.
    - 1: glitch; return to IDLE with no flags.
  - DATA: at cnt=CLKS_PER_BIT-1, sample the bit into shift[bidx] (LSB first) and set cnt=0. After bidx=7 is sampled, go to STOP. Otherwise bidx increments.
  - STOP: at cnt=CLKS_PER_BIT-1, sample rx_s:
    - 1: byte complete; go to IDLE.
    - 0: assert frame_err for one cycle, discard the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This rearms the receiver only after the line returns high.
- Sample timing: with the start edge seen on rx_s at cycle t, samples fall at t+H (start), t+H+k*CLKS_PER_BIT for k=1..8 (data), and t+H+9*CLKS_PER_BIT (stop).
- Byte completion: on the cycle after a good stop sample, data_valid=1, and data_out=shift if data_valid was 0.
- Output handshake:
  - data_valid stays high until data_ack=1 on a rising edge while data_valid=1, then drops next cycle.
  - A byte that completes in the same cycle as data_ack is accepted: data_out updates, data_valid stays 1, overrun is not set.
  - A byte that completes while data_valid=1 with no ack is dropped: data_out keeps the old byte and overrun=1.
  - overrun clears together with data_valid on data_ack.
- data_ack while data_valid=0 is ignored.
- A start edge is accepted in IDLE on the first cycle after returning from STOP; no inter-frame idle time is required beyond the stop-bit sample.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: every sample point (start, data, stop) uses the 2-of-3 majority of rx_s at cnt-1, cnt, and cnt+1 around the nominal sample point. The decision is registered at nominal+1, so internal transitions occur one cycle later. Output timing is shifted +1 cycle. Requires CLKS_PER_BIT>=4.
- Undefined: a single rx_s sample at the nominal point; no extra logic.

Test Plan (CLKS_PER_BIT=16, SYNC_STAGES=2):
- Drive frame 0xA5 on rx at 16 clk/bit, data_ack held 0 -> data_valid=1 and data_out=0xA5 exactly 2+8+9*16+1 cycles after the start edge on the pin; busy high during the frame; frame_err=0.
- rx low for 4 cycles, then high -> START aborts at half-bit; busy returns to 0; no data_valid, frame_err, or overrun.
- Frame 0x3C with stop bit driven 0 for 2 bit times, then high -> single-cycle frame_err; data_valid stays 0; a subsequent 0x55 frame is received only after the line returns high.
- Send 0x11 then 0x22 back-to-back, no ack -> data_out=0x11, overrun=1; then data_ack pulse -> data_valid=0, overrun=0 next cycle.
- Assert rst_n=0 mid-byte (bidx=4) for 3 cycles, then send 0x7E -> all outputs at reset values during reset; 0x7E received cleanly afterwards.
- 1-cycle high glitch on rx at the nominal sample of data bit 3 of 0x00 -> with UART_RX_MAJORITY_EN data_out=0x00; without it data_out=0x08.
